// File: rtl/issue_execute_fifo.sv
// rtl/issue_execute_fifo.sv - issue->execute show-ahead queue with commit-driven flush
package issue_execute_fifo_pkg;
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } issue_execute_pack_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } commit_feedback_pack_t;
endpackage

module issue_execute_fifo
    import issue_execute_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  issue_execute_pack_t         data_in,
    input  logic                        push,
    output logic                        full,
    output issue_execute_pack_t         data_out,
    output logic                        data_out_valid,
    input  logic                        pop,
    output logic [$clog2(DEPTH):0]      count,
    input  commit_feedback_pack_t       commit_feedback_pack
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    issue_execute_pack_t mem [DEPTH];

    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;

    logic flush;
    logic push_ok;
    logic pop_ok;

    assign full           = (count_q == CW'(DEPTH));
    assign data_out_valid = (count_q != '0);
    assign count          = count_q;
    // Zero when empty so consumers never see stale array contents.
    assign data_out       = data_out_valid ? mem[rptr_q] : '0;

    assign flush   = commit_feedback_pack.enable && commit_feedback_pack.flush;
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && data_out_valid && !flush;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= data_in;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert (count_q <= CW'(DEPTH)) else $error("count exceeds DEPTH");
            assert (!(push_ok && full)) else $error("push accepted while full");
            assert (!(pop_ok && !data_out_valid)) else $error("pop accepted while empty");
        end
    end
`endif
endmodule
